// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Bundles every non-clock signal of the ALU instruction sequencer:
//   - instruction handshake : instr_valid, instr, instr_ready
//   - register-file read    : rf_rs1_addr/rf_rs2_addr out, rf_rs1_data/rf_rs2_data in
//   - ALU                   : alu_a, alu_b, alu_op out, alu_result in
//   - register-file write   : rf_we, rf_rd_addr, rf_wd out
//   - status                : done, illegal, retired_count out
// modport master : the sequencer (it masters the register file and the ALU)
// modport slave  : the environment (instruction source, register file, ALU)
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [4:0]       rf_rs1_addr;
    logic [4:0]       rf_rs2_addr;
    logic [XLEN-1:0]  rf_rs1_data;
    logic [XLEN-1:0]  rf_rs2_data;
    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [4:0]       alu_op;
    logic [XLEN-1:0]  alu_result;
    logic             rf_we;
    logic [4:0]       rf_rd_addr;
    logic [XLEN-1:0]  rf_wd;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  instr_valid, instr, rf_rs1_data, rf_rs2_data, alu_result,
        output instr_ready, rf_rs1_addr, rf_rs2_addr, alu_a, alu_b, alu_op,
               rf_we, rf_rd_addr, rf_wd, done, illegal, retired_count
    );

    modport slave (
        output instr_valid, instr, rf_rs1_data, rf_rs2_data, alu_result,
        input  instr_ready, rf_rs1_addr, rf_rs2_addr, alu_a, alu_b, alu_op,
               rf_we, rf_rd_addr, rf_wd, done, illegal, retired_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle sequencer for RV32 R-type / I-type ALU instructions. Accepts one
// instruction per handshake in IDLE, decodes it to a 5-bit ALU op, then walks
// READ -> EXEC -> WB -> IDLE driving the shared register file and ALU.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   seq_io  : alu_seq_if.master (handshake, RF read/write, ALU, status)
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.master  seq_io
);
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_SLL  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_SLT  = 5'd8;
    localparam logic [4:0] OP_SLTU = 5'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Decode result packed as {legal, is_imm, alu_op}.
    function automatic logic [6:0] decode(input logic [31:0] ins);
        logic [6:0] res;
        logic [6:0] f7;
        logic [2:0] f3;
        f7  = ins[31:25];
        f3  = ins[14:12];
        res = 7'd0;
        case (ins[6:0])
            7'b0110011: begin
                case ({f7, f3})
                    10'b0000000_000: res = {1'b1, 1'b0, OP_ADD};
                    10'b0000000_001: res = {1'b1, 1'b0, OP_SLL};
                    10'b0000000_010: res = {1'b1, 1'b0, OP_SLT};
                    10'b0000000_011: res = {1'b1, 1'b0, OP_SLTU};
                    10'b0000000_100: res = {1'b1, 1'b0, OP_XOR};
                    10'b0000000_101: res = {1'b1, 1'b0, OP_SRL};
                    10'b0000000_110: res = {1'b1, 1'b0, OP_OR};
                    10'b0000000_111: res = {1'b1, 1'b0, OP_AND};
                    10'b0100000_000: res = {1'b1, 1'b0, OP_SUB};
                    10'b0100000_101: res = {1'b1, 1'b0, OP_SRA};
                    default:         res = 7'd0;
                endcase
            end
            7'b0010011: begin
                case (f3)
                    3'b000: res = {1'b1, 1'b1, OP_ADD};
                    3'b010: res = {1'b1, 1'b1, OP_SLT};
                    3'b011: res = {1'b1, 1'b1, OP_SLTU};
                    3'b100: res = {1'b1, 1'b1, OP_XOR};
                    3'b110: res = {1'b1, 1'b1, OP_OR};
                    3'b111: res = {1'b1, 1'b1, OP_AND};
                    3'b001: begin
                        if (f7 == 7'b0000000) res = {1'b1, 1'b1, OP_SLL};
                        else                  res = 7'd0;
                    end
                    3'b101: begin
                        if (f7 == 7'b0000000)      res = {1'b1, 1'b1, OP_SRL};
                        else if (f7 == 7'b0100000) res = {1'b1, 1'b1, OP_SRA};
                        else                       res = 7'd0;
                    end
                    default: res = 7'd0;
                endcase
            end
            default: res = 7'd0;
        endcase
        return res;
    endfunction

    // Shifts take a zero-extended shamt; everything else a sign-extended imm12.
    function automatic logic [XLEN-1:0] imm_of(input logic [31:0] ins);
        logic [XLEN-1:0] imm;
        if ((ins[14:12] == 3'b001) || (ins[14:12] == 3'b101)) begin
            imm = {{(XLEN-5){1'b0}}, ins[24:20]};
        end else begin
            imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
        end
        return imm;
    endfunction

    state_t           state_q;
    logic             ready_q;
    logic [4:0]       op_q;
    logic             is_imm_q;
    logic [XLEN-1:0]  imm_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic             exec_q;
    logic [4:0]       alu_op_q;
    logic             rf_we_q;
    logic [4:0]       rf_rd_q;
    logic [XLEN-1:0]  rf_wd_q;
    logic             done_q;
    logic             illegal_q;
    logic [CNT_W-1:0] count_q;
    logic [6:0]       dec_s;

    assign dec_s = decode(seq_io.instr);

    // Sequencer FSM: all outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            op_q      <= 5'd0;
            is_imm_q  <= 1'b0;
            imm_q     <= {XLEN{1'b0}};
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            exec_q    <= 1'b0;
            alu_op_q  <= 5'd0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_wd_q   <= {XLEN{1'b0}};
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (seq_io.instr_valid) begin
                        rd_q     <= seq_io.instr[11:7];
                        op_q     <= dec_s[4:0];
                        is_imm_q <= dec_s[5];
                        imm_q    <= imm_of(seq_io.instr);
                        if (dec_s[6]) begin
                            // Addresses go out now so the sync-read RF returns data in EXEC.
                            rs1_q   <= seq_io.instr[19:15];
                            rs2_q   <= seq_io.instr[24:20];
                            ready_q <= 1'b0;
                            state_q <= S_READ;
                        end else begin
                            illegal_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    alu_op_q <= op_q;
                    exec_q   <= 1'b1;
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    rf_wd_q  <= seq_io.alu_result;
                    rf_rd_q  <= rd_q;
                    rf_we_q  <= (rd_q != 5'd0);
                    done_q   <= 1'b1;
                    rs1_q    <= 5'd0;
                    rs2_q    <= 5'd0;
                    alu_op_q <= 5'd0;
                    exec_q   <= 1'b0;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    rf_we_q <= 1'b0;
                    rf_rd_q <= 5'd0;
                    rf_wd_q <= {XLEN{1'b0}};
                    count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    rf_we_q <= 1'b0;
                    exec_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is held low while reset is asserted and rises once it is released.
    assign seq_io.instr_ready   = ready_q & ~rst;
    assign seq_io.rf_rs1_addr   = rs1_q;
    assign seq_io.rf_rs2_addr   = rs2_q;
    // RF data only arrives during EXEC, so operands are a gated pass-through.
    assign seq_io.alu_a         = exec_q ? seq_io.rf_rs1_data : {XLEN{1'b0}};
    assign seq_io.alu_b         = exec_q ? (is_imm_q ? imm_q : seq_io.rf_rs2_data)
                                         : {XLEN{1'b0}};
    assign seq_io.alu_op        = alu_op_q;
    assign seq_io.rf_we         = rf_we_q;
    assign seq_io.rf_rd_addr    = rf_rd_q;
    assign seq_io.rf_wd         = rf_wd_q;
    assign seq_io.done          = done_q;
    assign seq_io.illegal       = illegal_q;
    assign seq_io.retired_count = count_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Two sequencers share one instruction stream and one register-file model:
// u_dut (CNT_W=16) is fully checked, u_dut2 (CNT_W=2) checks counter wrap.
// Directed vectors with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;
    logic clk;
    logic rst;

    alu_seq_if #(.XLEN(32), .CNT_W(16)) b1 ();
    alu_seq_if #(.XLEN(32), .CNT_W(2))  b2 ();

    alu_sequencer #(.XLEN(32), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .seq_io(b1));
    alu_sequencer #(.XLEN(32), .CNT_W(2))  u_dut2 (.clk(clk), .rst(rst), .seq_io(b2));

    typedef struct {
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic        we;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] rf [32];
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    int          done_cnt = 0;
    logic        we13_seen = 1'b0;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            5'd5:    return a << b[4:0];
            5'd6:    return a >> b[4:0];
            5'd7:    return $unsigned($signed(a) >>> b[4:0]);
            5'd8:    return {31'd0, ($signed(a) < $signed(b))};
            5'd9:    return {31'd0, (a < b)};
            default: return 32'd0;
        endcase
    endfunction

    assign b1.alu_result  = alu_f(b1.alu_op, b1.alu_a, b1.alu_b);
    assign b2.alu_result  = alu_f(b2.alu_op, b2.alu_a, b2.alu_b);
    assign b2.instr_valid = b1.instr_valid;
    assign b2.instr       = b1.instr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read register file model, written by u_dut only.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
        end else if (b1.rf_we && (b1.rf_rd_addr != 5'd0)) begin
            rf[b1.rf_rd_addr] <= b1.rf_wd;
        end
        b1.rf_rs1_data <= rf[b1.rf_rs1_addr];
        b1.rf_rs2_data <= rf[b1.rf_rs2_addr];
        b2.rf_rs1_data <= rf[b2.rf_rs1_addr];
        b2.rf_rs2_data <= rf[b2.rf_rs2_addr];
    end

    // Event monitors for write-abort and accept-once checks.
    always @(posedge clk) begin
        if (b1.rf_we && (b1.rf_rd_addr == 5'd13)) we13_seen <= 1'b1;
        if (b1.done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Offers an instruction and returns #1 after the accepting edge.
    task automatic offer(input logic [31:0] ins);
        int waited;
        @(negedge clk);
        b1.instr_valid = 1'b1;
        b1.instr       = ins;
        waited = 0;
        while (!b1.instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!b1.instr_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout actual=not_ready required=ready");
        end
        @(posedge clk);
        #1;
        b1.instr_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge of a legal instruction (cycle N+1).
    task automatic check_legal(input vec_t v);
        chk("read_rs1", {27'd0, b1.rf_rs1_addr}, {27'd0, v.ins[19:15]});
        chk("read_rs2", {27'd0, b1.rf_rs2_addr}, {27'd0, v.ins[24:20]});
        chk("read_ready", {31'd0, b1.instr_ready}, 32'd0);
        chk("read_aluop", {27'd0, b1.alu_op}, 32'd0);
        chk("read_we", {31'd0, b1.rf_we}, 32'd0);
        @(posedge clk); #1;
        chk("exec_aluop", {27'd0, b1.alu_op}, {27'd0, v.op});
        chk("exec_a", b1.alu_a, v.a);
        chk("exec_b", b1.alu_b, v.b);
        chk("exec_rs1", {27'd0, b1.rf_rs1_addr}, {27'd0, v.ins[19:15]});
        chk("exec_we", {31'd0, b1.rf_we}, 32'd0);
        @(posedge clk); #1;
        chk("wb_we", {31'd0, b1.rf_we}, {31'd0, v.we});
        chk("wb_rd", {27'd0, b1.rf_rd_addr}, {27'd0, v.ins[11:7]});
        chk("wb_wd", b1.rf_wd, v.wd);
        chk("wb_done", {31'd0, b1.done}, 32'd1);
        chk("wb_cnt_hold", {16'd0, b1.retired_count}, exp_cnt);
        chk("wb_alu_a", b1.alu_a, 32'd0);
        exp_cnt = exp_cnt + 1;
        @(posedge clk); #1;
        chk("idle_cnt", {16'd0, b1.retired_count}, exp_cnt);
        chk("idle_cnt2", {30'd0, b2.retired_count}, exp_cnt % 4);
        chk("idle_ready", {31'd0, b1.instr_ready}, 32'd1);
        chk("idle_done", {31'd0, b1.done}, 32'd0);
        chk("idle_we", {31'd0, b1.rf_we}, 32'd0);
        chk("idle_wd", b1.rf_wd, 32'd0);
    endtask

    // Called #1 after the accepting edge of an illegal instruction.
    task automatic check_illegal();
        chk("ill_pulse", {31'd0, b1.illegal}, 32'd1);
        chk("ill_ready", {31'd0, b1.instr_ready}, 32'd1);
        chk("ill_rs1", {27'd0, b1.rf_rs1_addr}, 32'd0);
        chk("ill_we", {31'd0, b1.rf_we}, 32'd0);
        @(posedge clk); #1;
        chk("ill_clear", {31'd0, b1.illegal}, 32'd0);
        chk("ill_cnt", {16'd0, b1.retired_count}, exp_cnt);
        chk("ill_done", {31'd0, b1.done}, 32'd0);
    endtask

    initial begin
        int d0;
        vecs[0]  = '{32'h002081B3, 1'b0, 5'd0, 32'd5,        32'd7,        32'd12,        1'b1};
        vecs[1]  = '{32'h40208233, 1'b0, 5'd1, 32'd5,        32'd7,        32'hFFFFFFFE,  1'b1};
        vecs[2]  = '{32'h4030D313, 1'b0, 5'd7, 32'd5,        32'd3,        32'd0,         1'b1};
        vecs[3]  = '{32'hFFF00293, 1'b0, 5'd0, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF,  1'b1};
        vecs[4]  = '{32'h00208033, 1'b0, 5'd0, 32'd5,        32'd7,        32'd12,        1'b0};
        vecs[5]  = '{32'h00002083, 1'b1, 5'd0, 32'd0,        32'd0,        32'd0,         1'b0};
        vecs[6]  = '{32'h0020C3B3, 1'b0, 5'd4, 32'd5,        32'd7,        32'd2,         1'b1};
        vecs[7]  = '{32'h00122433, 1'b0, 5'd8, 32'hFFFFFFFE, 32'd5,        32'd1,         1'b1};
        vecs[8]  = '{32'h001234B3, 1'b0, 5'd9, 32'hFFFFFFFE, 32'd5,        32'd0,         1'b1};
        vecs[9]  = '{32'h022081B3, 1'b1, 5'd0, 32'd0,        32'd0,        32'd0,         1'b0};
        vecs[10] = '{32'h40309313, 1'b1, 5'd0, 32'd0,        32'd0,        32'd0,         1'b0};
        vecs[11] = '{32'h00409513, 1'b0, 5'd5, 32'd5,        32'd4,        32'h00000050,  1'b1};
        vecs[12] = '{32'hFFC17593, 1'b0, 5'd2, 32'd7,        32'hFFFFFFFC, 32'd4,         1'b1};
        vecs[13] = '{32'h00125633, 1'b0, 5'd6, 32'hFFFFFFFE, 32'd5,        32'h07FFFFFF,  1'b1};

        rst = 1'b1;
        b1.instr_valid = 1'b0;
        b1.instr       = 32'd0;
        #1;
        chk("rst_ready", {31'd0, b1.instr_ready}, 32'd0);
        chk("rst_we", {31'd0, b1.rf_we}, 32'd0);
        chk("rst_done", {31'd0, b1.done}, 32'd0);
        chk("rst_cnt", {16'd0, b1.retired_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, b1.instr_ready}, 32'd1);
        chk("post_rst_cnt", {16'd0, b1.retired_count}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            offer(vecs[i].ins);
            if (vecs[i].ill) check_illegal();
            else             check_legal(vecs[i]);
        end

        // Illegal accepted, then a legal one accepted in the very next cycle.
        offer(32'h00002083);
        chk("b2b_ill", {31'd0, b1.illegal}, 32'd1);
        chk("b2b_ready", {31'd0, b1.instr_ready}, 32'd1);
        b1.instr_valid = 1'b1;
        b1.instr       = vecs[0].ins;
        @(posedge clk); #1;
        b1.instr_valid = 1'b0;
        chk("b2b_ill_clear", {31'd0, b1.illegal}, 32'd0);
        check_legal(vecs[0]);

        // Valid held through the busy cycles must be accepted exactly once.
        d0 = done_cnt;
        @(negedge clk);
        b1.instr_valid = 1'b1;
        b1.instr       = vecs[6].ins;
        @(posedge clk);
        repeat (3) @(negedge clk);
        b1.instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 1;
        chk("hold_done_once", done_cnt - d0, 32'd1);
        chk("hold_cnt", {16'd0, b1.retired_count}, exp_cnt);
        chk("hold_cnt2", {30'd0, b2.retired_count}, exp_cnt % 4);
        chk("hold_ready", {31'd0, b1.instr_ready}, 32'd1);

        // Reset during EXEC aborts the instruction with no write.
        offer(32'h002086B3);
        @(posedge clk); #1;
        chk("abort_in_exec", {27'd0, b1.alu_op}, 32'd0);
        chk("abort_exec_a", b1.alu_a, 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_a", b1.alu_a, 32'd0);
        chk("abort_rs1", {27'd0, b1.rf_rs1_addr}, 32'd0);
        chk("abort_we", {31'd0, b1.rf_we}, 32'd0);
        chk("abort_ready", {31'd0, b1.instr_ready}, 32'd0);
        chk("abort_cnt", {16'd0, b1.retired_count}, 32'd0);
        chk("abort_cnt2", {30'd0, b2.retired_count}, 32'd0);
        @(posedge clk); #1;
        chk("abort_we_hold", {31'd0, b1.rf_we}, 32'd0);
        chk("abort_done", {31'd0, b1.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_no_write", {31'd0, we13_seen}, 32'd0);
        chk("abort_ready_back", {31'd0, b1.instr_ready}, 32'd1);
        exp_cnt = 0;
        offer(vecs[0].ins);
        check_legal(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle instruction sequencer for the RISC-V ALU processor. Accepts one 32-bit R-type or I-type ALU instruction per handshake and decodes it to a 5-bit ALU operation. It then sequences register-file read, ALU execute and register-file writeback over a fixed four-state FSM. It sits between the instruction source and the shared register file and ALU, and is the only master of both.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  instruction word
- instr_ready  out  1  sequencer can accept; high only in IDLE
- rf_rs1_addr, rf_rs2_addr  out  5  register-file read addresses (synchronous-read RF: data valid one cycle later)
- rf_rs1_data, rf_rs2_data  in  XLEN  register-file read data
- alu_a, alu_b  out  XLEN  ALU operands
- alu_op  out  5  ALU operation code
- alu_result  in  XLEN  combinational ALU result
- rf_we  out  1  register-file write enable
- rf_rd_addr  out  5  write address
- rf_wd  out  XLEN  write data
- done  out  1  one-cycle pulse per retired instruction
- illegal  out  1  one-cycle pulse per rejected instruction
- retired_count  out  CNT_W  retired-instruction count

## Operation
alu_op encoding:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9

Decode for opcode 0110011 (R-type):
- funct7=0000000, by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- funct7=0100000: funct3 000 SUB, 101 SRA.
- Any other funct7/funct3 combination is illegal.

Decode for opcode 0010011 (I-type):
- funct3 000/010/011/100/110/111 give ADD/SLT/SLTU/XOR/OR/AND. Operand b is sign-extended instr[31:20].
- funct3 001 requires instr[31:25]=0000000 (SLL).
- funct3 101 requires instr[31:25]=0000000 (SRL) or 0100000 (SRA).
- For both shift forms, operand b is instr[24:20] zero-extended.
- Any other instr[31:25] value on a shift is illegal.

All other opcodes are illegal.

FSM states:
- IDLE: instr_ready=1. On instr_valid, latch instr and decoded fields.
  - Legal instruction: go to READ.
  - Illegal instruction: stay in IDLE and pulse illegal in the next cycle. Nothing is written and the count is unchanged.
- READ: drive rf_rs1_addr=instr[19:15] and rf_rs2_addr=instr[24:20] from the latched instruction. Go to EXEC.
- EXEC: drive alu_a=rf_rs1_data, alu_b=rf_rs2_data (R-type) or the immediate (I-type), and alu_op. Register alu_result. Read addresses stay stable. Go to WB.
- WB: drive rf_rd_addr=instr[11:7], rf_wd=the registered result, done=1, and rf_we=1 unless rd=0. Increment retired_count. Go to IDLE.

Output values outside their active state:
- rf_rs1_addr and rf_rs2_addr are 0 outside READ/EXEC.
- alu_a, alu_b and alu_op are 0 outside EXEC.
- rf_we, rf_rd_addr and rf_wd are 0 outside WB.

## Timing
- Reset (asynchronous, immediate): state=IDLE and all outputs 0, except instr_ready=1 once reset is released. retired_count=0 and the latched instruction is cleared.
- Handshake: transfer occurs on a rising edge with instr_valid && instr_ready. While instr_ready=0, instr_valid and instr are ignored. The source may hold valid across busy cycles.
- Latency for an instruction accepted at edge N:
  - READ in cycle N+1.
  - EXEC in cycle N+2; RF data arrives here.
  - WB in cycle N+3; rf_we, rf_wd and done are high, and retired_count updates at the end of that cycle.
  - IDLE in cycle N+4.
- Throughput: one instruction per 4 cycles. No back-to-back acceptance, because instr_ready is low in READ, EXEC and WB.
- Illegal accepted at edge N: illegal=1 in cycle N+1 only. instr_ready stays 1, so a new instruction can be accepted in that same cycle.
- rd=0: rf_we stays 0, but done pulses and the count increments.
- retired_count wraps from 2^CNT_W-1 to 0.
- Reset asserted in any state aborts the operation. No partial write may occur: rf_we drops the moment reset asserts.
- Arithmetic is in the ALU only. The sequencer performs only sign/zero extension to XLEN.

## Test plan
- x1=5, x2=7, instr ADD x3,x1,x2 (0x002081B3) -> in EXEC: alu_op=0, alu_a=5, alu_b=7. In WB (cycle N+3): rf_we=1, rd=3, wd=12, done=1. retired_count=1.
- SUB x4,x1,x2 (0x40208233) -> alu_op=1. SRAI x6,x1,3 (0x4030D313) -> alu_op=7, alu_b=3.
- ADDI x5,x0,-1 (0xFFF00293) -> alu_b=0xFFFFFFFF, wd equals the ALU result, rf_we=1.
- ADD x0,x1,x2 (0x00208033) -> rf_we stays 0 in all cycles, done=1, count increments. Load word 0x00002083 -> illegal=1 for one cycle, no write, count unchanged.
- Assert rst during EXEC of an ADD -> outputs go 0 immediately, no rf_we pulse, count=0. After release, the next instruction completes normally.
- CNT_W=2, retire 5 instructions -> count sequence 1,2,3,0,1. An instruction held valid through busy cycles is accepted exactly once.
